prf_wr_arbiter: RTL and testbench

Arbitrates the PRF_WR_COUNT writeback requesters onto the PRF_BANK_COUNT single-write-port PRF banks. Bank is selected by the PR's low LOG_PRF_BANK_COUNT bits. Each bank is arbitrated independently with a round-robin pointer. Granted writes are registered one cycle before driving bank write ports and the wakeup/complete broadcast. Sits between the functional-unit writeback stages and the PRF.

---
 rtl/core_types_pkg.sv | 15 +
 rtl/prf_wr_arbiter_pkg.sv | 16 +
 rtl/prf_wr_arbiter_rr.sv | 42 ++++
 rtl/prf_wr_arbiter.sv | 144 ++++++++++++++
 tb/tb_prf_wr_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_types_pkg.sv
// ----------------------------------------------------------------------------
// core_types_pkg
// Core-wide sizing constants shared by the backend blocks. The PRF write
// arbiter takes its defaults from here so that the requester count, bank
// count and register/data widths stay consistent with the rest of the core.
// ----------------------------------------------------------------------------
package core_types_pkg;

    localparam int PRF_WR_COUNT       = 7;   // writeback requesters into the PRF
    localparam int PRF_BANK_COUNT     = 4;   // single-write-port PRF banks
    localparam int LOG_PRF_BANK_COUNT = 2;   // bank select width
    localparam int LOG_PR_COUNT       = 7;   // physical register index width
    localparam int XLEN               = 32;  // architectural data width

endpackage

// File: rtl/prf_wr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// prf_wr_arbiter_pkg
// Types shared between the PRF write arbiter and its neighbours.
//   prf_wr_req_t : one writeback request {valid, destination PR, write data}
// ----------------------------------------------------------------------------
package prf_wr_arbiter_pkg;

    import core_types_pkg::*;

    typedef struct packed {
        logic                    valid;
        logic [LOG_PR_COUNT-1:0] PR;
        logic [XLEN-1:0]         data;
    } prf_wr_req_t;

endpackage

// File: rtl/prf_wr_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter_n
// Purely combinational N-input round-robin pick. The search starts at
// requester `ptr` and walks upward modulo N; the first asserted request wins.
//
// Ports:
//   req  in  [N]      request vector
//   ptr  in  [IDX_W]  first index to consider (always < N)
//   gnt  out [N]      one-hot grant (all zero when no request)
//   idx  out [IDX_W]  index of the granted requester (0 when none)
//   any  out 1        at least one request was granted
// ----------------------------------------------------------------------------
module rr_arbiter_n #(
    parameter int N     = 7,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = 0;
        for (int k = 0; k < N; k++) begin
            // Rotated scan order: ptr, ptr+1, ..., wrapping at N.
            pos = (int'(ptr) + k) % N;
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/prf_wr_arbiter.sv
// ----------------------------------------------------------------------------
// prf_wr_arbiter
// Arbitrates the functional-unit writeback requesters onto the banked PRF.
// The bank is the low LOG_N_BANK bits of the destination PR; every bank runs
// its own round-robin arbiter, so requesters aimed at different banks never
// block each other. Winners are registered once and then drive the bank write
// ports and the wakeup/complete broadcast in the following cycle.
//
// Ports:
//   CLK, nRST                 clock, asynchronous active-low reset
//   req_valid_by_wr  [N_REQ]  writeback request valid
//   req_PR_by_wr     [N_REQ]  destination PR
//   req_data_by_wr   [N_REQ]  write data
//   req_ready_by_wr  [N_REQ]  combinational grant (transfer on valid && ready)
//   bank_WEN_by_bank          registered bank write enable
//   bank_waddr_by_bank        registered in-bank index (PR >> LOG_N_BANK)
//   bank_wdata_by_bank        registered write data
//   complete_valid_by_bank    registered wakeup broadcast valid
//   complete_PR_by_bank       registered full PR for wakeup
// ----------------------------------------------------------------------------
module prf_wr_arbiter
    import core_types_pkg::*;
    import prf_wr_arbiter_pkg::*;
#(
    parameter int N_REQ      = PRF_WR_COUNT,
    parameter int N_BANK     = PRF_BANK_COUNT,
    parameter int LOG_N_BANK = LOG_PRF_BANK_COUNT,
    parameter int PR_W       = LOG_PR_COUNT,
    parameter int DATA_W     = XLEN
) (
    input  logic                                    CLK,
    input  logic                                    nRST,
    input  logic [N_REQ-1:0]                        req_valid_by_wr,
    input  logic [N_REQ-1:0][PR_W-1:0]              req_PR_by_wr,
    input  logic [N_REQ-1:0][DATA_W-1:0]            req_data_by_wr,
    output logic [N_REQ-1:0]                        req_ready_by_wr,
    output logic [N_BANK-1:0]                       bank_WEN_by_bank,
    output logic [N_BANK-1:0][PR_W-LOG_N_BANK-1:0]  bank_waddr_by_bank,
    output logic [N_BANK-1:0][DATA_W-1:0]           bank_wdata_by_bank,
    output logic [N_BANK-1:0]                       complete_valid_by_bank,
    output logic [N_BANK-1:0][PR_W-1:0]             complete_PR_by_bank
);

    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int ADDR_W = PR_W - LOG_N_BANK;

    // Pointer advance: one past the winner, wrapping at N_REQ so values
    // >= N_REQ are never produced.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    prf_wr_req_t                        req_p0     [N_REQ];
    prf_wr_req_t                        win_req_p0 [N_BANK];
    logic [N_BANK-1:0][N_REQ-1:0]       cand_p0;
    logic [N_BANK-1:0][N_REQ-1:0]       gnt_p0;
    logic [N_BANK-1:0][PTR_W-1:0]       win_idx_p0;
    logic [N_BANK-1:0]                  win_any_p0;
    logic [N_BANK-1:0][PTR_W-1:0]       rr_ptr;

    logic [N_BANK-1:0]                  vld_p1;
    logic [N_BANK-1:0][ADDR_W-1:0]      waddr_p1;
    logic [N_BANK-1:0][DATA_W-1:0]      wdata_p1;
    logic [N_BANK-1:0][PR_W-1:0]        pr_p1;

    // ---- stage p0: per-bank candidate selection and round-robin pick ----
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_p0[i].valid = req_valid_by_wr[i];
            req_p0[i].PR    = req_PR_by_wr[i];
            req_p0[i].data  = req_data_by_wr[i];
        end
    end

    always_comb begin
        cand_p0 = '0;
        for (int b = 0; b < N_BANK; b++) begin
            for (int i = 0; i < N_REQ; i++) begin
                cand_p0[b][i] = req_p0[i].valid &&
                                (req_p0[i].PR[LOG_N_BANK-1:0] == LOG_N_BANK'(b));
            end
        end
    end

    for (genvar gb = 0; gb < N_BANK; gb++) begin : g_bank_arb
        rr_arbiter_n #(
            .N     (N_REQ),
            .IDX_W (PTR_W)
        ) u_rr (
            .req (cand_p0[gb]),
            .ptr (rr_ptr[gb]),
            .gnt (gnt_p0[gb]),
            .idx (win_idx_p0[gb]),
            .any (win_any_p0[gb])
        );
    end

    // A requester targets exactly one bank, so OR-ing the per-bank grants
    // can never give one requester two grants.
    always_comb begin
        req_ready_by_wr = '0;
        for (int b = 0; b < N_BANK; b++) begin
            req_ready_by_wr = req_ready_by_wr | gnt_p0[b];
        end
    end

    always_comb begin
        for (int b = 0; b < N_BANK; b++) begin
            win_req_p0[b] = req_p0[win_idx_p0[b]];
        end
    end

    // ---- stage p1: registered bank write and wakeup broadcast ----
    // PR 0 is the hardwired-zero register: it is granted and advances the
    // pointer like any other write, but never writes the bank nor wakes up
    // dependents. The write and wakeup valids share one register since they
    // follow the same rule.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr   <= '0;
            vld_p1   <= '0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
            pr_p1    <= '0;
        end else begin
            for (int b = 0; b < N_BANK; b++) begin
                vld_p1[b] <= win_any_p0[b] && (win_req_p0[b].PR != '0);
                if (win_any_p0[b]) begin
                    rr_ptr[b]   <= next_ptr(win_idx_p0[b]);
                    waddr_p1[b] <= win_req_p0[b].PR[PR_W-1:LOG_N_BANK];
                    wdata_p1[b] <= win_req_p0[b].data;
                    pr_p1[b]    <= win_req_p0[b].PR;
                end
            end
        end
    end

    assign bank_WEN_by_bank       = vld_p1;
    assign complete_valid_by_bank = vld_p1;
    assign bank_waddr_by_bank     = waddr_p1;
    assign bank_wdata_by_bank     = wdata_p1;
    assign complete_PR_by_bank    = pr_p1;

endmodule

// File: tb/tb_prf_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_prf_wr_arbiter
// Directed scenarios plus a randomized run for prf_wr_arbiter. A reference
// model tracks one round-robin pointer per bank and the expected registered
// outputs, computed directly from the arbitration rules.
// ----------------------------------------------------------------------------
module tb_prf_wr_arbiter;

    localparam int NR  = 7;
    localparam int NB  = 4;
    localparam int PRW = 7;
    localparam int DW  = 32;
    localparam int AW  = 5;

    logic                     CLK = 1'b0;
    logic                     nRST;
    logic [NR-1:0]            req_valid;
    logic [NR-1:0][PRW-1:0]   req_pr;
    logic [NR-1:0][DW-1:0]    req_data;
    logic [NR-1:0]            ready;
    logic [NB-1:0]            wen;
    logic [NB-1:0][AW-1:0]    waddr;
    logic [NB-1:0][DW-1:0]    wdata;
    logic [NB-1:0]            cvld;
    logic [NB-1:0][PRW-1:0]   cpr;

    prf_wr_arbiter dut (
        .CLK                    (CLK),
        .nRST                   (nRST),
        .req_valid_by_wr        (req_valid),
        .req_PR_by_wr           (req_pr),
        .req_data_by_wr         (req_data),
        .req_ready_by_wr        (ready),
        .bank_WEN_by_bank       (wen),
        .bank_waddr_by_bank     (waddr),
        .bank_wdata_by_bank     (wdata),
        .complete_valid_by_bank (cvld),
        .complete_PR_by_bank    (cpr)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int                     mrr [NB];
    logic [NB-1:0]          m_wen;
    logic [NB-1:0]          m_cvld;
    logic [NB-1:0][AW-1:0]  m_waddr;
    logic [NB-1:0][DW-1:0]  m_wdata;
    logic [NB-1:0][PRW-1:0] m_cpr;
    logic [NR-1:0]          exp_ready;
    logic [NR-1:0]          seen_ready;

    function automatic int pick(int b);
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (mrr[b] + k) % NR;
            if (req_valid[i] && ((int'(req_pr[i]) % NB) == b)) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) mrr[b] = 0;
        m_wen   = '0;
        m_cvld  = '0;
        m_waddr = '0;
        m_wdata = '0;
        m_cpr   = '0;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_pr    = '0;
        req_data  = '0;
    endtask

    task automatic set_req(int i, int pr, logic [DW-1:0] d);
        req_valid[i] = 1'b1;
        req_pr[i]    = PRW'(pr);
        req_data[i]  = d;
    endtask

    // One clock with the current inputs: ready is checked before the edge,
    // registered outputs after it, both against the model.
    task automatic step(string tag);
        int w [NB];
        exp_ready = '0;
        for (int b = 0; b < NB; b++) begin
            w[b] = pick(b);
            if (w[b] >= 0) exp_ready[w[b]] = 1'b1;
        end
        #1;
        seen_ready = ready;
        n_total++;
        if (ready !== exp_ready)
            $display("FAIL %s ready got=%b want=%b", tag, ready, exp_ready);
        else n_pass++;
        @(posedge CLK);
        #1;
        for (int b = 0; b < NB; b++) begin
            if (w[b] >= 0) begin
                int i;
                i = w[b];
                m_wen[b]   = (int'(req_pr[i]) != 0);
                m_cvld[b]  = (int'(req_pr[i]) != 0);
                m_waddr[b] = AW'(int'(req_pr[i]) / NB);
                m_wdata[b] = req_data[i];
                m_cpr[b]   = req_pr[i];
                mrr[b]     = (i + 1) % NR;
            end else begin
                m_wen[b]  = 1'b0;
                m_cvld[b] = 1'b0;
            end
        end
        n_total++;
        if (wen !== m_wen) $display("FAIL %s bank_WEN got=%b want=%b", tag, wen, m_wen);
        else n_pass++;
        n_total++;
        if (cvld !== m_cvld) $display("FAIL %s complete_valid got=%b want=%b", tag, cvld, m_cvld);
        else n_pass++;
        n_total++;
        if (waddr !== m_waddr) $display("FAIL %s bank_waddr got=%h want=%h", tag, waddr, m_waddr);
        else n_pass++;
        n_total++;
        if (wdata !== m_wdata) $display("FAIL %s bank_wdata got=%h want=%h", tag, wdata, m_wdata);
        else n_pass++;
        n_total++;
        if (cpr !== m_cpr) $display("FAIL %s complete_PR got=%h want=%h", tag, cpr, m_cpr);
        else n_pass++;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        clear_reqs();
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        n_total++;
        if ({wen, cvld, waddr, wdata, cpr} !== '0)
            $display("FAIL reset_hold outputs got=%h want=0", {wen, cvld, waddr, wdata, cpr});
        else n_pass++;
        nRST = 1'b1;
        set_req(0, 4, $urandom);
        step("rst_pre");
        // Asynchronous reset mid-cycle while a write is registered
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        n_total++;
        if ({wen, cvld, waddr, wdata, cpr} !== '0)
            $display("FAIL reset_async outputs got=%h want=0", {wen, cvld, waddr, wdata, cpr});
        else n_pass++;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        clear_reqs();
        set_req(0, 4, $urandom);
        set_req(3, 8, $urandom);
        step("rst_first");
        n_total++;
        if (seen_ready !== 7'b0000001)
            $display("FAIL rst_first_grant ready got=%b want=%b", seen_ready, 7'b0000001);
        else n_pass++;
        clear_reqs();
    endtask

    task automatic test_fairness();
        int order [4] = '{0, 3, 6, 0};
        int addr  [4] = '{1, 2, 3, 1};
        logic [NR-1:0] oh;
        clear_reqs();
        set_req(0, 5, $urandom);
        set_req(3, 9, $urandom);
        set_req(6, 13, $urandom);
        for (int k = 0; k < 4; k++) begin
            step("fair");
            oh = NR'(1) << order[k];
            n_total++;
            if (seen_ready !== oh)
                $display("FAIL fair_order[%0d] ready got=%b want=%b", k, seen_ready, oh);
            else n_pass++;
            n_total++;
            if (wen[1] !== 1'b1 || waddr[1] !== AW'(addr[k]))
                $display("FAIL fair_waddr[%0d] wen=%b waddr=%0d want wen=1 waddr=%0d",
                         k, wen[1], waddr[1], addr[k]);
            else n_pass++;
        end
        clear_reqs();
    endtask

    task automatic test_parallel();
        clear_reqs();
        for (int i = 0; i < 4; i++) set_req(i, 4 + i, $urandom);
        step("par");
        n_total++;
        if (seen_ready !== 7'b0001111)
            $display("FAIL par_ready got=%b want=%b", seen_ready, 7'b0001111);
        else n_pass++;
        n_total++;
        if (wen !== 4'hF || waddr !== {4{5'd1}})
            $display("FAIL par_write wen=%b waddr=%h want wen=1111 waddr=%h", wen, waddr, {4{5'd1}});
        else n_pass++;
        n_total++;
        if (cpr !== {7'd7, 7'd6, 7'd5, 7'd4})
            $display("FAIL par_complete_PR got=%h want=%h", cpr, {7'd7, 7'd6, 7'd5, 7'd4});
        else n_pass++;
        clear_reqs();
    endtask

    task automatic test_pr0();
        clear_reqs();
        set_req(2, 0, 32'hDEADBEEF);
        step("pr0");
        n_total++;
        if (seen_ready !== 7'b0000100)
            $display("FAIL pr0_ready got=%b want=%b", seen_ready, 7'b0000100);
        else n_pass++;
        n_total++;
        if (wen[0] !== 1'b0 || cvld[0] !== 1'b0)
            $display("FAIL pr0_suppress wen=%b cvld=%b want 0 0", wen[0], cvld[0]);
        else n_pass++;
        // Pointer for bank 0 should now be 3: requester 3 beats requester 2.
        clear_reqs();
        set_req(2, 4, $urandom);
        set_req(3, 8, $urandom);
        step("pr0_ptr");
        n_total++;
        if (seen_ready !== 7'b0001000)
            $display("FAIL pr0_ptr_advance ready got=%b want=%b", seen_ready, 7'b0001000);
        else n_pass++;
        clear_reqs();
    endtask

    task automatic test_wrap();
        clear_reqs();
        set_req(5, 2, $urandom);
        step("wrap_setup");
        clear_reqs();
        set_req(6, 6, $urandom);
        set_req(1, 10, $urandom);
        step("wrap_a");
        n_total++;
        if (seen_ready !== 7'b1000000)
            $display("FAIL wrap_first ready got=%b want=%b", seen_ready, 7'b1000000);
        else n_pass++;
        req_valid[6] = 1'b0;
        step("wrap_b");
        n_total++;
        if (seen_ready !== 7'b0000010)
            $display("FAIL wrap_second ready got=%b want=%b", seen_ready, 7'b0000010);
        else n_pass++;
        clear_reqs();
        set_req(6, 14, $urandom);
        step("wrap_c");
        clear_reqs();
        set_req(0, 18, $urandom);
        set_req(6, 22, $urandom);
        step("wrap_d");
        n_total++;
        if (seen_ready !== 7'b0000001)
            $display("FAIL wrap_to_zero ready got=%b want=%b", seen_ready, 7'b0000001);
        else n_pass++;
        clear_reqs();
    endtask

    task automatic test_idle();
        logic [DW-1:0] d;
        d = $urandom;
        clear_reqs();
        set_req(4, 3, d);
        step("idle_grant");
        clear_reqs();
        step("idle");
        n_total++;
        if (wen !== '0 || cvld !== '0)
            $display("FAIL idle_valids wen=%b cvld=%b want 0", wen, cvld);
        else n_pass++;
        n_total++;
        if (wdata[3] !== d)
            $display("FAIL idle_wdata_hold got=%h want=%h", wdata[3], d);
        else n_pass++;
        set_req(4, 7, $urandom);
        set_req(5, 11, $urandom);
        step("idle_ptr");
        n_total++;
        if (seen_ready !== 7'b0100000)
            $display("FAIL idle_ptr_hold ready got=%b want=%b", seen_ready, 7'b0100000);
        else n_pass++;
        clear_reqs();
    endtask

    task automatic new_random_req(int i);
        if ($urandom_range(0, 9) < 7) begin
            req_valid[i] = 1'b1;
            req_pr[i]    = ($urandom_range(0, 15) == 0) ? '0 : PRW'($urandom_range(0, 127));
            req_data[i]  = $urandom;
        end else begin
            req_valid[i] = 1'b0;
        end
    endtask

    task automatic test_random();
        clear_reqs();
        for (int i = 0; i < NR; i++) new_random_req(i);
        for (int c = 0; c < 400; c++) begin
            step("rand");
            // Losers hold their request; granted or idle requesters re-roll.
            for (int i = 0; i < NR; i++) begin
                if (seen_ready[i] || !req_valid[i]) new_random_req(i);
            end
        end
        clear_reqs();
    endtask

    initial begin
        nRST = 1'b0;
        clear_reqs();
        test_reset();
        test_fairness();
        test_parallel();
        test_pr0();
        test_wrap();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
